// File: rtl/counter_seq_pkg.sv
// Shared types and default sizing for the counter sequencer and its datapath.
package counter_seq_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_DIV_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_e;

endpackage

// File: rtl/counter_core.sv
// Datapath up-counter: synchronous clear, steps on enable and wraps to zero
// after reaching the programmed terminal count.
module counter_core
    import counter_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] tc,
    output logic [WIDTH-1:0] q,
    output logic             at_tc
);

    logic [WIDTH-1:0] count_q;

    assign q     = count_q;
    assign at_tc = (count_q == tc);

    // Clear wins over enable so a fresh run always starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= at_tc ? '0 : count_q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/counter_sequencer.sv
// Run controller for the counter datapath: start/stop/pause FSM, clock
// prescaler, start-time configuration latch and tick/done pulse generation.
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic [WIDTH-1:0] cfg_tc,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             cfg_periodic,
    output logic [WIDTH-1:0] cnt_q,
    output logic             busy,
    output logic             tick,
    output logic             done
);

    state_e           state_q;
    logic [DIV_W-1:0] presc_q;
    logic [DIV_W-1:0] divL_q;
    logic [WIDTH-1:0] tcL_q;
    logic             perL_q;
    logic             busy_q;
    logic             tick_q;
    logic             done_q;

    logic             atTc;
    logic             accept_d;
    logic             presMatch_d;
    logic             stepEn_d;
    logic [WIDTH-1:0] nxtCnt_d;
    logic             nxtIsTc_d;

    assign accept_d    = (state_q == IDLE) && start && !stop;
    assign presMatch_d = (presc_q == divL_q);
    assign stepEn_d    = (state_q == RUN) && !stop && !pause && presMatch_d;
    assign nxtCnt_d    = atTc ? '0 : cnt_q + WIDTH'(1);
    assign nxtIsTc_d   = (nxtCnt_d == tcL_q);

    assign busy = busy_q;
    assign tick = tick_q;
    assign done = done_q;

    counter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (stepEn_d),
        .clr   (accept_d),
        .tc    (tcL_q),
        .q     (cnt_q),
        .at_tc (atTc)
    );

    // Stop is checked first in every busy state so it beats pause and any
    // coincident step; the counter enable above applies the same priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            presc_q <= '0;
            divL_q  <= '0;
            tcL_q   <= '0;
            perL_q  <= 1'b0;
            busy_q  <= 1'b0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        tcL_q   <= cfg_tc;
                        divL_q  <= cfg_div;
                        perL_q  <= cfg_periodic;
                        presc_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (pause) begin
                        state_q <= PAUSED;
                    end else if (presMatch_d) begin
                        presc_q <= '0;
                        tick_q  <= 1'b1;
                        done_q  <= nxtIsTc_d;
                        if (nxtIsTc_d && !perL_q) begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end else begin
                        presc_q <= presc_q + DIV_W'(1);
                    end
                end
                PAUSED: begin
                    if (stop) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (!pause) begin
                        state_q <= RUN;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench for counter_sequencer: table of cycle vectors plus
// hand-built pause/stop/reset sequences, checked through an expectation queue.
module tb_counter_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       pause;
    logic [3:0] cfg_tc;
    logic [3:0] cfg_div;
    logic       cfg_periodic;
    logic [3:0] cnt_q;
    logic       busy;
    logic       tick;
    logic       done;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       start;
        logic       stop;
        logic       pause;
        logic [3:0] tc;
        logic [3:0] dv;
        logic       per;
        logic [3:0] eCnt;
        logic       eBusy;
        logic       eTick;
        logic       eDone;
    } vec_t;

    typedef struct {
        logic [3:0] cnt;
        logic       busy;
        logic       tick;
        logic       done;
        string      tag;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    counter_sequencer #(
        .WIDTH (4),
        .DIV_W (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .pause        (pause),
        .cfg_tc       (cfg_tc),
        .cfg_div      (cfg_div),
        .cfg_periodic (cfg_periodic),
        .cnt_q        (cnt_q),
        .busy         (busy),
        .tick         (tick),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkVec(input logic st, input logic sp, input logic pa,
                                   input logic [3:0] tc, input logic [3:0] dv,
                                   input logic pe, input logic [3:0] c,
                                   input logic b, input logic t, input logic d);
        vec_t v;
        v.start = st; v.stop = sp; v.pause = pa;
        v.tc = tc; v.dv = dv; v.per = pe;
        v.eCnt = c; v.eBusy = b; v.eTick = t; v.eDone = d;
        return v;
    endfunction

    task automatic checkVal(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_empty actual=0 expected=1");
            return;
        end
        e = sb.pop_front();
        checkVal({e.tag, ".cnt"},  cnt_q,     e.cnt);
        checkVal({e.tag, ".busy"}, 4'(busy),  4'(e.busy));
        checkVal({e.tag, ".tick"}, 4'(tick),  4'(e.tick));
        checkVal({e.tag, ".done"}, 4'(done),  4'(e.done));
    endtask

    task automatic applyStimulus(input vec_t v, input string tag);
        exp_t e;
        start        = v.start;
        stop         = v.stop;
        pause        = v.pause;
        cfg_tc       = v.tc;
        cfg_div      = v.dv;
        cfg_periodic = v.per;
        e.cnt  = v.eCnt;
        e.busy = v.eBusy;
        e.tick = v.eTick;
        e.done = v.eDone;
        e.tag  = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0; stop = 1'b0; pause = 1'b0;
        cfg_tc = 4'd0; cfg_div = 4'd0; cfg_periodic = 1'b0;

        // One-shot tc=5 div=0: five back-to-back steps, done and busy drop at 5.
        vecs.push_back(mkVec(1, 0, 0, 4'd5, 4'd0, 0, 4'd0, 1, 0, 0));
        for (int c = 1; c <= 5; c++)
            vecs.push_back(mkVec(0, 0, 0, 4'd5, 4'd0, 0, 4'(c), c != 5, 1, c == 5));
        vecs.push_back(mkVec(0, 0, 0, 4'd5, 4'd0, 0, 4'd5, 0, 0, 0));

        // Periodic tc=2 div=3: step every fourth clock, sequence 1,2,0,...
        vecs.push_back(mkVec(1, 0, 0, 4'd2, 4'd3, 1, 4'd0, 1, 0, 0));
        for (int k = 1; k <= 24; k++) begin
            logic t;
            logic [3:0] c;
            t = (k % 4 == 0);
            c = 4'((k / 4) % 3);
            vecs.push_back(mkVec(0, 0, 0, 4'd2, 4'd3, 1, c, 1, t, t && (c == 4'd2)));
        end
        vecs.push_back(mkVec(0, 1, 0, 4'd2, 4'd3, 1, 4'd0, 0, 0, 0));

        // tc=0 one-shot: tick and done together on the first step.
        vecs.push_back(mkVec(1, 0, 0, 4'd0, 4'd0, 0, 4'd0, 1, 0, 0));
        vecs.push_back(mkVec(0, 0, 0, 4'd0, 4'd0, 0, 4'd0, 0, 1, 1));
        vecs.push_back(mkVec(0, 0, 0, 4'd0, 4'd0, 0, 4'd0, 0, 0, 0));

        // tc=15 periodic wraps to 0; a start and new cfg mid-run are ignored.
        vecs.push_back(mkVec(1, 0, 0, 4'd15, 4'd0, 1, 4'd0, 1, 0, 0));
        for (int k = 1; k <= 17; k++)
            vecs.push_back(mkVec(k == 5, 0, 0, (k >= 5) ? 4'd3 : 4'd15,
                                 (k >= 5) ? 4'd2 : 4'd0, k < 5,
                                 4'(k % 16), 1, 1, k == 15));
        vecs.push_back(mkVec(0, 1, 0, 4'd3, 4'd2, 0, 4'd1, 0, 0, 0));

        repeat (2) @(posedge clk);
        #1;
        checkVal("reset.cnt",  cnt_q,    4'd0);
        checkVal("reset.busy", 4'(busy), 4'd0);
        checkVal("reset.tick", 4'(tick), 4'd0);
        checkVal("reset.done", 4'(done), 4'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            applyStimulus(vecs[i], $sformatf("vec%0d", i));

        // Pause for six cycles at cnt=1 with the prescaler frozen at its last phase.
        applyStimulus(mkVec(1, 0, 0, 4'd3, 4'd1, 1, 4'd0, 1, 0, 0), "pause.start");
        applyStimulus(mkVec(0, 0, 0, 4'd3, 4'd1, 1, 4'd0, 1, 0, 0), "pause.k1");
        applyStimulus(mkVec(0, 0, 0, 4'd3, 4'd1, 1, 4'd1, 1, 1, 0), "pause.k2");
        applyStimulus(mkVec(0, 0, 0, 4'd3, 4'd1, 1, 4'd1, 1, 0, 0), "pause.k3");
        for (int k = 0; k < 6; k++)
            applyStimulus(mkVec(0, 0, 1, 4'd3, 4'd1, 1, 4'd1, 1, 0, 0), $sformatf("pause.hold%0d", k));
        applyStimulus(mkVec(0, 0, 0, 4'd3, 4'd1, 1, 4'd1, 1, 0, 0), "pause.release");
        applyStimulus(mkVec(0, 0, 0, 4'd3, 4'd1, 1, 4'd2, 1, 1, 0), "pause.resume");
        applyStimulus(mkVec(0, 0, 0, 4'd3, 4'd1, 1, 4'd2, 1, 0, 0), "pause.r2");
        applyStimulus(mkVec(0, 0, 0, 4'd3, 4'd1, 1, 4'd3, 1, 1, 1), "pause.tc");
        applyStimulus(mkVec(0, 0, 0, 4'd3, 4'd1, 1, 4'd3, 1, 0, 0), "pause.r4");
        applyStimulus(mkVec(0, 0, 0, 4'd3, 4'd1, 1, 4'd0, 1, 1, 0), "pause.wrap");
        applyStimulus(mkVec(0, 1, 0, 4'd3, 4'd1, 1, 4'd0, 0, 0, 0), "pause.stop");

        // Stop on the edge that would reach tc, then restart with new cfg.
        applyStimulus(mkVec(1, 0, 0, 4'd2, 4'd0, 0, 4'd0, 1, 0, 0), "stop.start");
        applyStimulus(mkVec(0, 0, 0, 4'd2, 4'd0, 0, 4'd1, 1, 1, 0), "stop.k1");
        applyStimulus(mkVec(0, 1, 0, 4'd2, 4'd0, 0, 4'd1, 0, 0, 0), "stop.attc");
        applyStimulus(mkVec(0, 0, 0, 4'd2, 4'd0, 0, 4'd1, 0, 0, 0), "stop.hold");
        applyStimulus(mkVec(1, 0, 0, 4'd3, 4'd0, 0, 4'd0, 1, 0, 0), "stop.restart");
        applyStimulus(mkVec(0, 0, 0, 4'd3, 4'd0, 0, 4'd1, 1, 1, 0), "stop.r1");
        applyStimulus(mkVec(0, 0, 0, 4'd3, 4'd0, 0, 4'd2, 1, 1, 0), "stop.r2");
        applyStimulus(mkVec(0, 0, 0, 4'd3, 4'd0, 0, 4'd3, 0, 1, 1), "stop.r3");
        applyStimulus(mkVec(1, 1, 0, 4'd9, 4'd0, 0, 4'd3, 0, 0, 0), "stop.startstop");
        applyStimulus(mkVec(0, 1, 0, 4'd9, 4'd0, 0, 4'd3, 0, 0, 0), "stop.idle");
        applyStimulus(mkVec(1, 0, 0, 4'd5, 4'd0, 1, 4'd0, 1, 0, 0), "stop.s2");
        applyStimulus(mkVec(0, 0, 0, 4'd5, 4'd0, 1, 4'd1, 1, 1, 0), "stop.s2k1");
        applyStimulus(mkVec(0, 1, 1, 4'd5, 4'd0, 1, 4'd1, 0, 0, 0), "stop.overpause");

        // Asynchronous reset in the middle of a run at cnt=3.
        applyStimulus(mkVec(1, 0, 0, 4'd7, 4'd0, 1, 4'd0, 1, 0, 0), "rst.start");
        applyStimulus(mkVec(0, 0, 0, 4'd7, 4'd0, 1, 4'd1, 1, 1, 0), "rst.k1");
        applyStimulus(mkVec(0, 0, 0, 4'd7, 4'd0, 1, 4'd2, 1, 1, 0), "rst.k2");
        applyStimulus(mkVec(0, 0, 0, 4'd7, 4'd0, 1, 4'd3, 1, 1, 0), "rst.k3");
        #2;
        rst_n = 1'b0;
        #1;
        checkVal("rst.async.cnt",  cnt_q,    4'd0);
        checkVal("rst.async.busy", 4'(busy), 4'd0);
        checkVal("rst.async.tick", 4'(tick), 4'd0);
        checkVal("rst.async.done", 4'(done), 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(mkVec(0, 0, 0, 4'd7, 4'd0, 1, 4'd0, 0, 0, 0), "rst.after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
